// File: rtl/range_encoder.sv
// range_encoder: two-stage valid/ready thermometer-to-index encoder with bubble detection and saturating error count
module range_encoder #(
  parameter int W = 32,
  parameter int CNT_W = 16,
  localparam int IDX_W = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_zero,
  output logic             out_bubble,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             clr_err
);
  logic             s1_valid_q;
  logic [W-1:0]     s1_word_q;
  logic             out_valid_q;
  logic [IDX_W-1:0] out_idx_q;
  logic             out_zero_q;
  logic             out_bubble_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] err_cnt_d;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_zero;
  logic             enc_bubble;
  logic             s2_free;
  logic             s1_free;
  assign s2_free    = ~out_valid_q | out_ready;
  assign s1_free    = ~s1_valid_q | s2_free;
  assign in_ready   = s1_free;
  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign out_zero   = out_zero_q;
  assign out_bubble = out_bubble_q;
  assign err_cnt    = err_cnt_q;
  always_comb begin
    enc_idx = '0;
    for (int i = 0; i < W; i++)
      if (s1_word_q[i]) enc_idx = IDX_W'(i);
  end
  // A thermometer code plus one is a power of two, so word & (word+1) is zero only then
  assign enc_zero   = ~|s1_word_q;
  assign enc_bubble = ~enc_zero & |(s1_word_q & (s1_word_q + W'(1)));
  assign err_cnt_d  = clr_err ? '0
                    : (out_valid_q & out_ready & out_bubble_q & ~&err_cnt_q) ? err_cnt_q + CNT_W'(1)
                    : err_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_word_q    <= '0;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_zero_q   <= 1'b0;
      out_bubble_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      if (in_valid && s1_free) begin
        s1_valid_q <= 1'b1;
        s1_word_q  <= in_word;
      end else if (s2_free) begin
        s1_valid_q <= 1'b0;
      end
      if (s2_free) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_idx_q    <= enc_idx;
          out_zero_q   <= enc_zero;
          out_bubble_q <= enc_bubble;
        end
      end
      err_cnt_q <= err_cnt_d;
    end
  end
endmodule
